// File: rtl/psum_accum_stage_pkg.sv
`default_nettype none
// ============================================================================
//  psum_accum_stage_pkg
//  Shared widths, psum type, saturation bounds and FSM encoding.
//  Revision: 1.0
// ============================================================================
package psum_accum_stage_pkg;

  localparam int AuODWd  = 16;
  localparam int DWd     = 24;
  localparam int PsumNCh = 4;
  localparam int PsumShW = 4;

  typedef logic signed [DWd-1:0] psum_t;

  localparam psum_t PsumMax = {1'b0, {(DWd-1){1'b1}}};
  localparam psum_t PsumMin = {1'b1, {(DWd-1){1'b0}}};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } acc_state_e;

endpackage
`default_nettype wire

// File: rtl/psum_accum_stage_if.sv
`default_nettype none
// ============================================================================
//  psum_accum_stage_if
//  Beat input and psum output handshake bundle of the accumulation stage.
//  Revision: 1.0
// ============================================================================
interface psum_accum_stage_if
  import psum_accum_stage_pkg::*;
#(
  parameter int NCH   = PsumNCh,
  parameter int SUM_W = AuODWd,
  parameter int DW    = DWd,
  parameter int SHW   = PsumShW
);

  logic                       i_valid;
  logic                       o_ready;
  logic                       i_init;
  logic                       i_fstpix;
  logic                       i_lstpix;
  logic                       i_sht_en;
  logic [SHW-1:0]             i_sht_amt;
  logic [NCH-1:0][SUM_W-1:0]  i_sum;
  logic [NCH-1:0][DW-1:0]     i_psum;
  logic                       o_valid;
  logic                       i_ready;
  logic [NCH-1:0][DW-1:0]     o_psum;
  logic [NCH-1:0]             o_sat;
  logic                       o_proto_err;

  modport master (
    output i_valid, i_init, i_fstpix, i_lstpix, i_sht_en, i_sht_amt,
           i_sum, i_psum, i_ready,
    input  o_ready, o_valid, o_psum, o_sat, o_proto_err
  );

  modport slave (
    input  i_valid, i_init, i_fstpix, i_lstpix, i_sht_en, i_sht_amt,
           i_sum, i_psum, i_ready,
    output o_ready, o_valid, o_psum, o_sat, o_proto_err
  );

endinterface
`default_nettype wire

// File: rtl/psum_accum_stage_lane.sv
`default_nettype none
// ============================================================================
//  psum_lane
//  One lane: saturating accumulate, then optional round-half-up shift.
//  Revision: 1.0
// ============================================================================
module psum_lane
  import psum_accum_stage_pkg::*;
#(
  parameter int SUM_W = AuODWd,
  parameter int DW    = DWd,
  parameter int SHW   = PsumShW
) (
  input  logic signed [DW-1:0]    base_i,
  input  logic signed [SUM_W-1:0] sum_i,
  input  logic                    sht_en_i,
  input  logic [SHW-1:0]          sht_amt_i,
  output logic signed [DW-1:0]    acc_o,
  output logic                    clamp_o,
  output logic signed [DW-1:0]    out_o
);

  localparam logic signed [DW:0] MAX_W = {2'b00, {(DW-1){1'b1}}};
  localparam logic signed [DW:0] MIN_W = {2'b11, {(DW-1){1'b0}}};

  function automatic logic signed [DW-1:0] sat_dw(input logic signed [DW:0] x);
    if (x > MAX_W)      sat_dw = MAX_W[DW-1:0];
    else if (x < MIN_W) sat_dw = MIN_W[DW-1:0];
    else                sat_dw = x[DW-1:0];
  endfunction

  logic signed [DW:0] w_add;
  logic signed [DW:0] w_inc;
  logic signed [DW:0] w_rnd;
  logic signed [DW:0] w_shf;

  always_comb begin
    // One guard bit is enough: DW > SUM_W so the sum cannot wrap in DW+1 bits
    w_add   = $signed({base_i[DW-1], base_i}) +
              $signed({{(DW+1-SUM_W){sum_i[SUM_W-1]}}, sum_i});
    clamp_o = (w_add > MAX_W) || (w_add < MIN_W);
    acc_o   = sat_dw(w_add);

    w_inc = '0;
    if (sht_amt_i != '0) begin
      w_inc = {{DW{1'b0}}, 1'b1} << (sht_amt_i - 1'b1);
    end
    w_rnd = $signed({acc_o[DW-1], acc_o}) + w_inc;
    w_shf = w_rnd >>> sht_amt_i;
    out_o = sht_en_i ? sat_dw(w_shf) : acc_o;
  end

endmodule
`default_nettype wire

// File: rtl/psum_accum_stage.sv
`default_nettype none
// ============================================================================
//  psum_accum_stage
//  NCH-lane psum accumulator with pass FSM, output register and handshake.
//  Revision: 1.0
// ============================================================================
module psum_accum_stage
  import psum_accum_stage_pkg::*;
#(
  parameter int NCH   = PsumNCh,
  parameter int SUM_W = AuODWd,
  parameter int DW    = DWd,
  parameter int SHW   = PsumShW
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_stall,
  psum_accum_stage_if.slave  bus
);

  acc_state_e              state_q, state_d;
  logic [NCH-1:0][DW-1:0]  acc_q, acc_d;
  logic [NCH-1:0][DW-1:0]  psum_q, psum_d;
  logic                    valid_q, valid_d;
  logic [NCH-1:0]          sat_q, sat_d;
  logic                    err_q, err_d;

  logic                    w_ready;
  logic                    w_accept;
  logic                    w_fst_eff;
  logic                    w_init_eff;
  logic [NCH-1:0][DW-1:0]  w_base;
  logic [NCH-1:0][DW-1:0]  w_lane_acc;
  logic [NCH-1:0][DW-1:0]  w_lane_out;
  logic [NCH-1:0]          w_lane_clamp;

  assign w_ready  = !i_stall && !(valid_q && !bus.i_ready);
  assign w_accept = bus.i_valid && w_ready;

  // A non-first beat arriving in IDLE is recovered as a fresh zero-seeded pass
  assign w_fst_eff  = bus.i_fstpix || (state_q == ST_IDLE);
  assign w_init_eff = bus.i_init || (state_q == ST_IDLE && !bus.i_fstpix);

  always_comb begin
    w_base = '0;
    for (int l = 0; l < NCH; l++) begin
      if (w_fst_eff) w_base[l] = w_init_eff ? '0 : bus.i_psum[l];
      else           w_base[l] = acc_q[l];
    end
  end

  for (genvar l = 0; l < NCH; l++) begin : g_lane
    psum_lane #(
      .SUM_W (SUM_W),
      .DW    (DW),
      .SHW   (SHW)
    ) u_lane (
      .base_i    (w_base[l]),
      .sum_i     (bus.i_sum[l]),
      .sht_en_i  (bus.i_sht_en),
      .sht_amt_i (bus.i_sht_amt),
      .acc_o     (w_lane_acc[l]),
      .clamp_o   (w_lane_clamp[l]),
      .out_o     (w_lane_out[l])
    );
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    psum_d  = psum_q;
    valid_d = valid_q;
    sat_d   = sat_q;
    err_d   = err_q;

    if (valid_q && bus.i_ready) valid_d = 1'b0;

    if (w_accept) begin
      acc_d   = w_lane_acc;
      sat_d   = w_fst_eff ? w_lane_clamp : (sat_q | w_lane_clamp);
      state_d = bus.i_lstpix ? ST_IDLE : ST_ACC;
      if ((state_q == ST_IDLE && !bus.i_fstpix) ||
          (state_q == ST_ACC && bus.i_fstpix)) begin
        err_d = 1'b1;
      end
      if (bus.i_lstpix) begin
        psum_d  = w_lane_out;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_q   <= '0;
      psum_q  <= '0;
      valid_q <= 1'b0;
      sat_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      psum_q  <= psum_d;
      valid_q <= valid_d;
      sat_q   <= sat_d;
      err_q   <= err_d;
    end
  end

  assign bus.o_ready     = w_ready;
  assign bus.o_valid     = valid_q;
  assign bus.o_psum      = psum_q;
  assign bus.o_sat       = sat_q;
  assign bus.o_proto_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_psum_accum_stage.sv
`default_nettype none
// ============================================================================
//  tb_psum_accum_stage
//  Directed vector table plus reset / saturation-floor sequences.
//  Revision: 1.0
// ============================================================================
module tb_psum_accum_stage;

  localparam int NCH   = 4;
  localparam int SUM_W = 16;
  localparam int DW    = 24;
  localparam int SHW   = 4;
  localparam int NVEC  = 23;

  typedef struct packed {
    logic                      rst;
    logic                      stall;
    logic                      valid;
    logic                      init;
    logic                      fst;
    logic                      lst;
    logic                      shen;
    logic [SHW-1:0]            amt;
    logic [NCH-1:0][SUM_W-1:0] sum;
    logic [NCH-1:0][DW-1:0]    psum;
    logic                      rdy;
    logic                      e_rdy;
    logic                      e_val;
    logic [NCH-1:0][DW-1:0]    e_psum;
    logic [NCH-1:0]            e_sat;
    logic                      e_err;
  } vec_t;

  logic clk;
  logic rst;
  logic stall;
  int   n_tests;
  int   n_fail;
  vec_t vecs [NVEC];
  vec_t hv;

  psum_accum_stage_if #(.NCH(NCH), .SUM_W(SUM_W), .DW(DW), .SHW(SHW)) bus ();

  psum_accum_stage #(
    .NCH   (NCH),
    .SUM_W (SUM_W),
    .DW    (DW),
    .SHW   (SHW)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_stall (stall),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input int st, input int va, input int in, input int fs,
                              input int ls, input int sh, input int amt, input int s,
                              input int p, input int rd, input int erd, input int ev,
                              input int ep, input int es, input int ee);
    vec_t v;
    v       = '0;
    v.stall = st[0];
    v.valid = va[0];
    v.init  = in[0];
    v.fst   = fs[0];
    v.lst   = ls[0];
    v.shen  = sh[0];
    v.amt   = SHW'(amt);
    v.rdy   = rd[0];
    v.e_rdy = erd[0];
    v.e_val = ev[0];
    v.e_sat = NCH'(es);
    v.e_err = ee[0];
    for (int l = 0; l < NCH; l++) begin
      v.sum[l]    = SUM_W'(s);
      v.psum[l]   = DW'(p);
      v.e_psum[l] = DW'(ep);
    end
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [95:0] act,
                     input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    rst           = v.rst;
    stall         = v.stall;
    bus.i_valid   = v.valid;
    bus.i_init    = v.init;
    bus.i_fstpix  = v.fst;
    bus.i_lstpix  = v.lst;
    bus.i_sht_en  = v.shen;
    bus.i_sht_amt = v.amt;
    bus.i_sum     = v.sum;
    bus.i_psum    = v.psum;
    bus.i_ready   = v.rdy;
    #1;
    chk("o_ready", idx, 96'(bus.o_ready), 96'(v.e_rdy));
    @(posedge clk);
    #1;
    chk("o_valid", idx, 96'(bus.o_valid), 96'(v.e_val));
    chk("o_psum", idx, 96'(bus.o_psum), 96'(v.e_psum));
    chk("o_sat", idx, 96'(bus.o_sat), 96'(v.e_sat));
    chk("o_proto_err", idx, 96'(bus.o_proto_err), 96'(v.e_err));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    //            st va in fs ls sh amt  sum    psum  rd  erd ev  e_psum   es  ee
    vecs[0]  = mk(0, 1, 1, 1, 0, 0, 0,   100,   0,    1,  1, 0,  0,       0,  0);
    vecs[1]  = mk(0, 1, 0, 0, 0, 0, 0,   100,   0,    1,  1, 0,  0,       0,  0);
    vecs[2]  = mk(0, 1, 0, 0, 1, 0, 0,   100,   0,    1,  1, 1,  300,     0,  0);
    vecs[3]  = mk(0, 1, 0, 1, 0, 0, 0,   10,    -1000,1,  1, 0,  300,     0,  0);
    vecs[4]  = mk(0, 1, 0, 0, 0, 0, 0,   20,    0,    1,  1, 0,  300,     0,  0);
    vecs[5]  = mk(0, 1, 0, 0, 1, 0, 0,   30,    0,    1,  1, 1,  -940,    0,  0);
    vecs[6]  = mk(0, 1, 0, 1, 1, 0, 0,   100,   0,    1,  1, 1,  100,     1,  0);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0,   0,     0,    1,  1, 0,  100,     1,  0);
    vecs[8]  = mk(0, 1, 1, 1, 0, 0, 0,   5,     0,    1,  1, 0,  100,     0,  0);
    vecs[9]  = mk(0, 1, 0, 0, 1, 1, 4,   35,    0,    1,  1, 1,  3,       0,  0);
    vecs[10] = mk(0, 1, 1, 1, 1, 1, 4,   -40,   0,    1,  1, 1,  -2,      0,  0);
    vecs[11] = mk(0, 1, 1, 1, 1, 1, 0,   77,    0,    1,  1, 1,  77,      0,  0);
    vecs[12] = mk(0, 1, 1, 1, 1, 0, 0,   9,     0,    0,  0, 1,  77,      0,  0);
    vecs[13] = mk(0, 1, 1, 1, 1, 0, 0,   9,     0,    1,  1, 1,  9,       0,  0);
    vecs[14] = mk(0, 0, 0, 0, 0, 0, 0,   0,     0,    1,  1, 0,  9,       0,  0);
    vecs[15] = mk(0, 1, 1, 1, 0, 0, 0,   1000,  0,    1,  1, 0,  9,       0,  0);
    vecs[16] = mk(1, 1, 0, 0, 0, 0, 0,   500,   0,    1,  0, 0,  9,       0,  0);
    vecs[17] = mk(1, 1, 0, 0, 1, 0, 0,   7,     0,    1,  0, 0,  9,       0,  0);
    vecs[18] = mk(0, 1, 0, 0, 0, 0, 0,   500,   0,    1,  1, 0,  9,       0,  0);
    vecs[19] = mk(0, 1, 0, 0, 1, 0, 0,   25,    0,    1,  1, 1,  1525,    0,  0);
    vecs[20] = mk(0, 1, 1, 1, 0, 0, 0,   3,     0,    1,  1, 0,  1525,    0,  0);
    vecs[21] = mk(0, 1, 1, 1, 0, 0, 0,   4,     0,    1,  1, 0,  1525,    0,  1);
    vecs[22] = mk(0, 1, 0, 0, 1, 0, 0,   6,     0,    1,  1, 1,  10,      0,  1);
    // Lane 0 alone is seeded just below the positive rail and clamps
    vecs[6].psum[0]   = DW'(8388598);
    vecs[6].e_psum[0] = DW'(8388607);
    vecs[7].e_psum[0] = DW'(8388607);
    vecs[8].e_psum[0] = DW'(8388607);

    rst           = 1'b1;
    stall         = 1'b0;
    bus.i_valid   = 1'b0;
    bus.i_init    = 1'b0;
    bus.i_fstpix  = 1'b0;
    bus.i_lstpix  = 1'b0;
    bus.i_sht_en  = 1'b0;
    bus.i_sht_amt = '0;
    bus.i_sum     = '0;
    bus.i_psum    = '0;
    bus.i_ready   = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready", 0, 96'(bus.o_ready), 96'(1));
    chk("rst_valid", 0, 96'(bus.o_valid), 96'(0));
    chk("rst_psum", 0, 96'(bus.o_psum), 96'(0));
    chk("rst_sat", 0, 96'(bus.o_sat), 96'(0));
    chk("rst_err", 0, 96'(bus.o_proto_err), 96'(0));

    for (int i = 0; i < NVEC; i++) apply(vecs[i], i);

    // Reset mid-pass, then a stray mid/last beat restarts from zero
    hv = mk(0, 1, 1, 1, 0, 0, 0, 50, 0, 1, 1, 0, 10, 0, 1);
    apply(hv, 100);
    hv = mk(0, 1, 0, 0, 0, 0, 0, 20, 0, 1, 1, 0, 0, 0, 0);
    hv.rst = 1'b1;
    apply(hv, 101);
    hv = mk(0, 1, 0, 0, 1, 0, 0, 11, 0, 1, 1, 1, 11, 0, 1);
    apply(hv, 102);

    // Negative rail on every lane in a single-pixel pass
    hv = mk(0, 1, 0, 1, 1, 0, 0, -100, -8388600, 1, 1, 1, -8388608, 15, 1);
    apply(hv, 103);
    hv = mk(0, 1, 0, 1, 1, 1, 3, -4, 20, 1, 1, 1, 2, 0, 1);
    apply(hv, 104);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
